dense_layer_sequencer: RTL and testbench
========================================

Name: dense_layer_sequencer

Overview:
Time-multiplexes one shared dense-column datapath (multiply-by-weight, adder tree, bias add) across all OUTPUT_SIZE neurons of a dense layer. It latches an input vector on start and issues one neuron index per cycle to the column unit. It tracks in-flight results through a tag pipeline matched to the datapath latency, captures each result (optional ReLU) into an output buffer, then presents the full vector with a valid/ready handshake.

Parameters:
WIDTH, 16, fixed-point word width (signed)
NFRAC, 10, fractional bits (pass-through to column unit; no rescaling here)
INPUT_SIZE, 128, input vector length
OUTPUT_SIZE, 10, number of neurons (column issues per inference), >=1
PIPE_LATENCY, 8, cycles from col_sel presented to matching col_result valid, >=1
RELU, 1, 1 = clamp negative captured results to 0; 0 = store raw

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
start  input  1  request new inference; accepted only in IDLE
data_in  input  WIDTH x INPUT_SIZE  signed input vector, sampled on accepted start
busy  output  1  high whenever state != IDLE
data_hold  output  WIDTH x INPUT_SIZE  latched input vector driven to column unit
col_issue  output  1  high in cycles where col_sel is a valid issue
col_sel  output  $clog2(OUTPUT_SIZE) (min 1)  neuron index (selects weight set/bias in column unit)
col_result  input  WIDTH  signed column output, valid PIPE_LATENCY cycles after matching issue
out_valid  output  1  output vector complete and stable
out_ready  input  1  consumer accepts vector
out_data  output  WIDTH x OUTPUT_SIZE  result buffer, index = neuron index

Behaviour:
- Reset (sync, high): state=IDLE, busy=0, col_issue=0, col_sel=0, out_valid=0, data_hold all 0, out_data all 0, tag pipeline cleared. Reset mid-operation discards all in-flight work; results arriving afterwards are ignored.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 at edge E0 -> data_hold<=data_in, idx<=0, state<=ISSUE. start=0 -> stay.
- ISSUE: col_issue=1, col_sel=idx (combinational from idx). Each edge: idx++; when idx==OUTPUT_SIZE-1 -> DRAIN. Exactly OUTPUT_SIZE issue cycles, indices 0..OUTPUT_SIZE-1 in order, one per cycle, no gaps.
- Tag pipeline: PIPE_LATENCY-deep shift register of {valid, sel}; stage 0 loads {col_issue, col_sel} each edge. When last stage valid, col_result is stored at that edge into out_data[sel] (ReLU applied if RELU=1: MSB set -> 0).
- Timing: issue k presented in cycle k after E0; result valid in cycle k+PIPE_LATENCY; captured at following edge.
- DRAIN: col_issue=0; when final capture (sel=OUTPUT_SIZE-1) occurs -> DONE, out_valid<=1 at the same edge. out_valid first high OUTPUT_SIZE+PIPE_LATENCY cycles after E0.
- DONE: out_valid=1, out_data stable. out_valid&&out_ready at edge -> IDLE, out_valid<=0. out_data retains values until overwritten by next inference.
- start while not IDLE (incl. DONE with simultaneous out_ready) ignored; no queuing. data_hold changes only on accepted start.
- out_ready while out_valid=0 ignored.
- OUTPUT_SIZE=1: ISSUE lasts one cycle then DRAIN.
- No arithmetic on results besides optional ReLU; widths pass through unchanged.

Test Plan:
- OUTPUT_SIZE=4, PIPE_LATENCY=3, model column as result = 100*sel - 150 (delayed 3 cycles), RELU=0; start pulse -> col_sel 0,1,2,3 in consecutive cycles, out_valid high exactly 7 cycles after start edge, out_data = {-150,-50,50,150}.
- Same with RELU=1 -> out_data = {0,0,50,150}.
- Hold out_ready=0 for 5 cycles after out_valid -> out_valid and out_data stable; out_ready=1 -> out_valid low next cycle, busy=0.
- start asserted during ISSUE, DRAIN, and in DONE together with out_ready -> no new issue; only a later start in IDLE launches; data_hold unchanged by ignored starts.
- Reset asserted mid-ISSUE (after col_sel=1) -> next cycle busy=0, col_issue=0, out_data all 0; late col_result values not captured; fresh start runs full 4-issue sequence correctly.
- Defaults (OUTPUT_SIZE=10, PIPE_LATENCY=8), back-to-back inferences with out_ready tied high -> each out_valid at start+18 cycles, one-cycle pulse, data matches model.

Source files
------------

// File: rtl/dense_layer_sequencer.sv
// ============================================================================
// dense_layer_sequencer: issues one neuron index per cycle to a shared
// dense-column datapath and collects delayed results into an output vector.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dense_layer_sequencer #(
    parameter int WIDTH        = 16,
    parameter int NFRAC        = 10,
    parameter int INPUT_SIZE   = 128,
    parameter int OUTPUT_SIZE  = 10,
    parameter int PIPE_LATENCY = 8,
    parameter int RELU         = 1,
    localparam int SEL_W       = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WIDTH*INPUT_SIZE-1:0]   data_in,
    output logic                          busy,
    output logic [WIDTH*INPUT_SIZE-1:0]   data_hold,
    output logic                          col_issue,
    output logic [SEL_W-1:0]              col_sel,
    input  logic [WIDTH-1:0]              col_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH*OUTPUT_SIZE-1:0]  out_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(OUTPUT_SIZE - 1);

    state_t           state;
    logic [SEL_W-1:0] idx;
    logic             tag_valid [PIPE_LATENCY];
    logic [SEL_W-1:0] tag_sel   [PIPE_LATENCY];
    logic [WIDTH-1:0] capture_val;
    logic             capture_en;
    logic [SEL_W-1:0] capture_sel;

    assign busy        = (state != S_IDLE);
    assign col_sel     = idx;
    assign capture_en  = tag_valid[PIPE_LATENCY-1];
    assign capture_sel = tag_sel[PIPE_LATENCY-1];
    // Negative results are clamped only when the ReLU option is enabled.
    assign capture_val = ((RELU != 0) && col_result[WIDTH-1]) ? '0 : col_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            col_issue <= 1'b0;
            out_valid <= 1'b0;
            data_hold <= '0;
            out_data  <= '0;
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                tag_valid[i] <= 1'b0;
                tag_sel[i]   <= '0;
            end
        end else begin
            // The tag pipeline mirrors the column latency so each result
            // arrives together with the neuron index that produced it.
            for (int i = PIPE_LATENCY - 1; i > 0; i--) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_sel[i]   <= tag_sel[i-1];
            end
            tag_valid[0] <= col_issue;
            tag_sel[0]   <= idx;

            if (capture_en) begin
                for (int i = 0; i < OUTPUT_SIZE; i++) begin
                    if (capture_sel == SEL_W'(i)) begin
                        out_data[i*WIDTH +: WIDTH] <= capture_val;
                    end
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        data_hold <= data_in;
                        idx       <= '0;
                        col_issue <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (idx == LAST_SEL) begin
                        idx       <= '0;
                        col_issue <= 1'b0;
                        state     <= S_DRAIN;
                    end else begin
                        idx <= idx + SEL_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (capture_en && (capture_sel == LAST_SEL)) begin
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dense_layer_sequencer.sv
// ============================================================================
// tb_dense_layer_sequencer: scoreboard bench for dense_layer_sequencer with
// small (4 neurons, latency 3, ReLU off/on) and default configurations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dense_layer_sequencer;

    typedef struct {
        logic [159:0] data;
        int           cyc;
    } exp_t;

    localparam logic [159:0] EXP_A = 160'h0096_0032_FFCE_FF6A; // -150,-50,50,150
    localparam logic [159:0] EXP_B = 160'h0096_0032_0000_0000; // 0,0,50,150

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // small configuration, A = raw, B = ReLU
    logic        start_ab = 1'b0;
    logic [63:0] din_ab = '0;
    logic        ready_ab = 1'b0;
    logic        busy_a, iss_a, val_a, busy_b, iss_b, val_b;
    logic [63:0] hold_a, dat_a, hold_b, dat_b;
    logic [1:0]  sel_a, sel_b;
    logic [15:0] res_a, res_b;

    // default configuration
    logic          start_c = 1'b0;
    logic [2047:0] din_c = '0;
    logic          ready_c = 1'b1;
    logic          busy_c, iss_c, val_c;
    logic [2047:0] hold_c;
    logic [159:0]  dat_c, EXP_C;
    logic [3:0]    sel_c;
    logic [15:0]   res_c;

    dense_layer_sequencer #(.WIDTH(16), .NFRAC(10), .INPUT_SIZE(4), .OUTPUT_SIZE(4),
                            .PIPE_LATENCY(3), .RELU(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_ab), .data_in(din_ab), .busy(busy_a),
        .data_hold(hold_a), .col_issue(iss_a), .col_sel(sel_a), .col_result(res_a),
        .out_valid(val_a), .out_ready(ready_ab), .out_data(dat_a));

    dense_layer_sequencer #(.WIDTH(16), .NFRAC(10), .INPUT_SIZE(4), .OUTPUT_SIZE(4),
                            .PIPE_LATENCY(3), .RELU(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_ab), .data_in(din_ab), .busy(busy_b),
        .data_hold(hold_b), .col_issue(iss_b), .col_sel(sel_b), .col_result(res_b),
        .out_valid(val_b), .out_ready(ready_ab), .out_data(dat_b));

    dense_layer_sequencer dut_c (
        .clk(clk), .reset(reset), .start(start_c), .data_in(din_c), .busy(busy_c),
        .data_hold(hold_c), .col_issue(iss_c), .col_sel(sel_c), .col_result(res_c),
        .out_valid(val_c), .out_ready(ready_c), .out_data(dat_c));

    // Column models: result = 100*sel - 150, valid PIPE_LATENCY cycles later.
    function automatic logic [15:0] colf(input int s);
        return 16'(100 * s - 150);
    endfunction

    logic [1:0] cp_a [3];
    logic [1:0] cp_b [3];
    logic [3:0] cp_c [8];

    always @(posedge clk) begin
        cp_a[0] <= sel_a;
        cp_b[0] <= sel_b;
        cp_c[0] <= sel_c;
        for (int i = 1; i < 3; i++) begin
            cp_a[i] <= cp_a[i-1];
            cp_b[i] <= cp_b[i-1];
        end
        for (int i = 1; i < 8; i++) cp_c[i] <= cp_c[i-1];
    end

    assign res_a = colf(int'(cp_a[2]));
    assign res_b = colf(int'(cp_b[2]));
    assign res_c = colf(int'(cp_c[7]));

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // Scoreboard queues and monitors
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    logic pv_a = 1'b0, pv_b = 1'b0, pv_c = 1'b0;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (val_a && !pv_a) begin
            if (qa.size() == 0) check("a_unexpected_valid", 160'(val_a), 160'(0));
            else begin
                e = qa.pop_front();
                check("a_out_data", 160'(dat_a), e.data);
                check("a_valid_cycle", 160'(cyc), 160'(e.cyc));
            end
        end
        pv_a = val_a;
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (val_b && !pv_b) begin
            if (qb.size() == 0) check("b_unexpected_valid", 160'(val_b), 160'(0));
            else begin
                e = qb.pop_front();
                check("b_out_data", 160'(dat_b), e.data);
                check("b_valid_cycle", 160'(cyc), 160'(e.cyc));
            end
        end
        pv_b = val_b;
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (val_c && !pv_c) begin
            if (qc.size() == 0) check("c_unexpected_valid", 160'(val_c), 160'(0));
            else begin
                e = qc.pop_front();
                check("c_out_data", dat_c, e.data);
                check("c_valid_cycle", 160'(cyc), 160'(e.cyc));
            end
        end
        pv_c = val_c;
    end

    function automatic logic vld(input int which);
        return (which == 0) ? val_a : val_c;
    endfunction

    task automatic wait_valid(input int which, input int limit);
        int n = 0;
        while (!vld(which) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_out_valid", 160'(vld(which)), 160'(1));
    endtask

    // Called at a negedge; returns at the negedge of the last checked cycle
    // (cycle 4 / DRAIN when all four issues are checked).
    task automatic launch_ab(input logic [63:0] d, input bit hold, input bit push, input int nchk);
        exp_t e;
        start_ab = 1'b1;
        din_ab   = d;
        @(posedge clk);
        @(negedge clk);
        if (hold) din_ab = ~d;
        else start_ab = 1'b0;
        if (push) begin
            e.cyc = cyc + 7;
            e.data = EXP_A;
            qa.push_back(e);
            e.data = EXP_B;
            qb.push_back(e);
        end
        for (int k = 0; k < nchk; k++) begin
            if (k > 0) @(negedge clk);
            check("issue_active", 160'(iss_a), 160'(1));
            check("issue_sel", 160'(sel_a), 160'(k));
            if (k == 1) check("data_hold", 160'(hold_a), 160'(d));
        end
        if (nchk == 4) begin
            @(negedge clk);
            check("drain_no_issue", 160'({iss_a, iss_b}), 160'(0));
            check("drain_busy", 160'(busy_a), 160'(1));
        end
    endtask

    task automatic launch_c(input logic [2047:0] d);
        exp_t e;
        start_c = 1'b1;
        din_c   = d;
        @(posedge clk);
        @(negedge clk);
        start_c = 1'b0;
        e.cyc  = cyc + 18;
        e.data = EXP_C;
        qc.push_back(e);
        check("c_issue_sel0", 160'({iss_c, sel_c}), 160'({1'b1, 4'd0}));
        @(negedge clk);
        check("c_issue_sel1", 160'({iss_c, sel_c}), 160'({1'b1, 4'd1}));
        check("c_data_hold", 160'(hold_c == d), 160'(1));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int tbl [10] = '{0, 0, 50, 150, 250, 350, 450, 550, 650, 750};
        logic [2047:0] dc;
        for (int i = 0; i < 10; i++) EXP_C[i*16 +: 16] = 16'(tbl[i]);

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 160'({busy_a, busy_b, busy_c}), 160'(0));
        check("rst_issue", 160'({iss_a, iss_c}), 160'(0));
        check("rst_sel", 160'({sel_a, sel_c}), 160'(0));
        check("rst_valid", 160'({val_a, val_b, val_c}), 160'(0));
        check("rst_hold", 160'(hold_a), 160'(0));
        check("rst_out_data", 160'({dat_a, dat_b}), 160'(0));
        reset = 1'b0;

        // basic inference, ReLU off/on
        ready_ab = 1'b1;
        launch_ab(64'h0004_0003_0002_0001, 1'b0, 1'b1, 4);
        wait_valid(0, 20);
        @(negedge clk);
        check("t1_valid_drop", 160'({val_a, val_b}), 160'(0));
        check("t1_idle", 160'(busy_a), 160'(0));

        // consumer stall, start in DONE ignored
        ready_ab = 1'b0;
        launch_ab(64'h1111_2222_3333_4444, 1'b0, 1'b1, 4);
        wait_valid(0, 20);
        start_ab = 1'b1;
        din_ab   = 64'hDEAD_BEEF_0BAD_F00D;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 160'({val_a, val_b}), 160'(2'b11));
            check("stall_data_a", 160'(dat_a), EXP_A);
            check("stall_data_b", 160'(dat_b), EXP_B);
        end
        ready_ab = 1'b1;
        @(negedge clk);
        check("release_valid", 160'(val_a), 160'(0));
        check("release_busy", 160'(busy_a), 160'(0));
        start_ab = 1'b0;
        @(negedge clk);
        check("done_start_ignored", 160'(busy_a), 160'(0));
        check("done_hold_kept", 160'(hold_a), 160'(64'h1111_2222_3333_4444));

        // start held high through ISSUE and DRAIN
        launch_ab(64'h0A0A_0B0B_0C0C_0D0D, 1'b1, 1'b1, 4);
        @(negedge clk);
        start_ab = 1'b0;
        wait_valid(0, 20);
        check("busy_start_hold", 160'(hold_a), 160'(64'h0A0A_0B0B_0C0C_0D0D));
        @(negedge clk);
        @(negedge clk);
        check("no_requeue", 160'({busy_a, iss_a}), 160'(0));

        // reset mid-ISSUE
        launch_ab(64'h5555_6666_7777_8888, 1'b0, 1'b0, 2);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy_issue", 160'({busy_a, iss_a}), 160'(0));
        check("midrst_out_data", 160'({dat_a, dat_b}), 160'(0));
        check("midrst_hold", 160'(hold_a), 160'(0));
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("late_results_ignored", 160'({dat_a, dat_b, val_a}), 160'(0));
        launch_ab(64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 4);
        wait_valid(0, 20);
        @(negedge clk);
        check("post_rst_idle", 160'(busy_a), 160'(0));

        // default configuration, back-to-back with ready tied high
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 128; i++) dc[i*16 +: 16] = 16'(i * 3 + r * 7);
            launch_c(dc);
            wait_valid(1, 40);
            @(negedge clk);
            check("c_pulse_one_cycle", 160'({val_c, busy_c}), 160'(0));
        end

        check("qa_empty", 160'(qa.size()), 160'(0));
        check("qb_empty", 160'(qb.size()), 160'(0));
        check("qc_empty", 160'(qc.size()), 160'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
